alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_op_decode.sv | 103 ++++++++++
 rtl/alu_issue_stage.sv | 85 ++++++++
 tb/tb_alu_issue_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, rv32i opcode/funct constants and immediate
// extraction helpers for the ALU issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_NONE = 4'b1111
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    function automatic logic [11:0] immI(input logic [31:0] instr);
        return instr[31:20];
    endfunction

    function automatic logic [11:0] immS(input logic [31:0] instr);
        return {instr[31:25], instr[11:7]};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an rv32i word into ALU control, the selected
// immediate and an illegal flag for anything outside AND/OR/ADD/SUB.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output alu_op_t         o_aluOp,
    output logic [XLEN-1:0] o_imm,
    output logic            o_useImm,
    output logic            o_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_immI;
    logic [XLEN-1:0] w_immS;
    logic            w_unusedRs1Idx;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Arithmetic sign extension of the 12-bit immediates to the datapath width
    assign w_immI = {{(XLEN-12){i_instr[31]}}, immI(i_instr)};
    assign w_immS = {{(XLEN-12){i_instr[31]}}, immS(i_instr)};

    // The rs1 index is resolved by the register file before this stage
    assign w_unusedRs1Idx = ^i_instr[19:15];

    always_comb begin
        o_aluOp   = ALU_NONE;
        o_imm     = w_immI;
        o_useImm  = 1'b0;
        o_illegal = 1'b1;

        case (w_opcode)
            OP_R: begin
                if (w_funct3 == F3_ADD && w_funct7 == F7_BASE) begin
                    o_aluOp   = ALU_ADD;
                    o_illegal = 1'b0;
                end else if (w_funct3 == F3_ADD && w_funct7 == F7_ALT) begin
                    o_aluOp   = ALU_SUB;
                    o_illegal = 1'b0;
                end else if (w_funct3 == F3_AND && w_funct7 == F7_BASE) begin
                    o_aluOp   = ALU_AND;
                    o_illegal = 1'b0;
                end else if (w_funct3 == F3_OR && w_funct7 == F7_BASE) begin
                    o_aluOp   = ALU_OR;
                    o_illegal = 1'b0;
                end
            end
            OP_IMM: begin
                case (w_funct3)
                    F3_ADD: begin
                        o_aluOp   = ALU_ADD;
                        o_useImm  = 1'b1;
                        o_illegal = 1'b0;
                    end
                    F3_AND: begin
                        o_aluOp   = ALU_AND;
                        o_useImm  = 1'b1;
                        o_illegal = 1'b0;
                    end
                    F3_OR: begin
                        o_aluOp   = ALU_OR;
                        o_useImm  = 1'b1;
                        o_illegal = 1'b0;
                    end
                    default: begin
                        o_aluOp   = ALU_NONE;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            // Loads and stores only need the address adder
            OP_LOAD: begin
                o_aluOp   = ALU_ADD;
                o_useImm  = 1'b1;
                o_illegal = 1'b0;
            end
            OP_STORE: begin
                o_aluOp   = ALU_ADD;
                o_imm     = w_immS;
                o_useImm  = 1'b1;
                o_illegal = 1'b0;
            end
            OP_BRANCH: begin
                if (w_funct3 == F3_ADD || w_funct3 == F3_BNE) begin
                    o_aluOp   = ALU_SUB;
                    o_illegal = 1'b0;
                end
            end
            default: begin
                o_aluOp   = ALU_NONE;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry valid/ready issue register feeding the ALU: decodes the incoming
// instruction, muxes operand B and holds the payload under backpressure.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] in_a,
    output logic [XLEN-1:0] in_b,
    output logic [4:0]      rd,
    output logic            illegal
);

    alu_op_t         w_aluOp;
    logic [XLEN-1:0] w_imm;
    logic            w_useImm;
    logic            w_illegal;
    logic [XLEN-1:0] w_opB;
    logic            w_inReady;
    logic            w_load;

    logic            r_outValid;
    alu_op_t         r_aluOp;
    logic [XLEN-1:0] r_inA;
    logic [XLEN-1:0] r_inB;
    logic [4:0]      r_rd;
    logic            r_illegal;

    alu_op_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (instr),
        .o_aluOp   (w_aluOp),
        .o_imm     (w_imm),
        .o_useImm  (w_useImm),
        .o_illegal (w_illegal)
    );

    assign w_opB     = w_useImm ? w_imm : rs2_data;
    assign w_inReady = !r_outValid || out_ready;
    assign w_load    = in_valid && w_inReady && !flush;

    // Flush wins over load and drain; payload may go stale once invalidated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_aluOp    <= ALU_NONE;
            r_inA      <= '0;
            r_inB      <= '0;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_aluOp    <= w_aluOp;
            r_inA      <= rs1_data;
            r_inB      <= w_opB;
            r_rd       <= instr[11:7];
            r_illegal  <= w_illegal;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign alu_op    = r_aluOp;
    assign in_a      = r_inA;
    assign in_b      = r_inB;
    assign rd        = r_rd;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: expected entries are queued
// on acceptance and compared against the registered outputs.
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      rd;
    logic            illegal;

    entry_t scoreboard[$];
    int     compareCount = 0;
    int     failCount    = 0;

    alu_issue_stage #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .rd        (rd),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_alu_op", {28'd0, alu_op}, 32'hF);
        checkOutput("rst_in_a", in_a, 32'd0);
        checkOutput("rst_in_b", in_b, 32'd0);
        checkOutput("rst_rd", {27'd0, rd}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    endtask

    // Called just after a falling edge: drive, check, update model, advance one cycle
    task automatic applyStimulus(input logic [31:0] iInstr, input logic [31:0] iRs1,
                                 input logic [31:0] iRs2, input logic iValid,
                                 input logic iReady, input logic iFlush,
                                 input logic [3:0] eOp, input logic [31:0] eA,
                                 input logic [31:0] eB, input logic [4:0] eRd,
                                 input logic eIll);
        logic   held;
        logic   accept;
        entry_t e;
        instr     = iInstr;
        rs1_data  = iRs1;
        rs2_data  = iRs2;
        in_valid  = iValid;
        out_ready = iReady;
        flush     = iFlush;
        #1;
        held = (scoreboard.size() != 0);
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, held});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!held || iReady)});
        if (held && out_valid) begin
            checkOutput("alu_op", {28'd0, alu_op}, {28'd0, scoreboard[0].op});
            checkOutput("in_a", in_a, scoreboard[0].a);
            checkOutput("in_b", in_b, scoreboard[0].b);
            checkOutput("rd", {27'd0, rd}, {27'd0, scoreboard[0].rd});
            checkOutput("illegal", {31'd0, illegal}, {31'd0, scoreboard[0].ill});
        end
        accept = iValid && (!held || iReady) && !iFlush;
        if (iFlush) begin
            scoreboard.delete();
        end else begin
            if (held && iReady) void'(scoreboard.pop_front());
            if (accept) begin
                e.op  = eOp;
                e.a   = eA;
                e.b   = eB;
                e.rd  = eRd;
                e.ill = eIll;
                scoreboard.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'd5;
        rs2_data  = 32'd7;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkResetState();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // Decode coverage at full throughput
        applyStimulus(32'h002081B3, 32'd5,      32'd7,      1, 1, 0, 4'b0010, 32'd5,      32'd7,        5'd3, 0);
        applyStimulus(32'h402081B3, 32'd9,      32'd4,      1, 1, 0, 4'b0110, 32'd9,      32'd4,        5'd3, 0);
        applyStimulus(32'hFFF00093, 32'd0,      32'd77,     1, 1, 0, 4'b0010, 32'd0,      32'hFFFFFFFF, 5'd1, 0);
        applyStimulus(32'h0020A223, 32'h100,    32'hDEAD,   1, 1, 0, 4'b0010, 32'h100,    32'd4,        5'd4, 0);
        applyStimulus(32'h007372B3, 32'hF0F0,   32'hFF00,   1, 1, 0, 4'b0000, 32'hF0F0,   32'hFF00,     5'd5, 0);
        applyStimulus(32'h007362B3, 32'hF0F0,   32'h0F00,   1, 1, 0, 4'b0001, 32'hF0F0,   32'h0F00,     5'd5, 0);
        applyStimulus(32'hFF017093, 32'h1234,   32'd1,      1, 1, 0, 4'b0000, 32'h1234,   32'hFFFFFFF0, 5'd1, 0);
        applyStimulus(32'h00812083, 32'h2000,   32'd1,      1, 1, 0, 4'b0010, 32'h2000,   32'd8,        5'd1, 0);
        applyStimulus(32'h00208063, 32'd3,      32'd3,      1, 1, 0, 4'b0110, 32'd3,      32'd3,        5'd0, 0);
        applyStimulus(32'h00209133, 32'd11,     32'd22,     1, 1, 0, 4'b1111, 32'd11,     32'd22,       5'd2, 1);
        applyStimulus(32'h123452B7, 32'hA,      32'hB,      1, 1, 0, 4'b1111, 32'hA,      32'hB,        5'd5, 1);

        // Backpressure: held add must stay put while the next sub waits
        applyStimulus(32'h002081B3, 32'd1,      32'd2,      1, 1, 0, 4'b0010, 32'd1,      32'd2,        5'd3, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h402081B3, 32'd8,  32'd3,      1, 0, 0, 4'b0110, 32'd8,      32'd3,        5'd3, 0);
        applyStimulus(32'h402081B3, 32'd8,      32'd3,      1, 1, 0, 4'b0110, 32'd8,      32'd3,        5'd3, 0);
        applyStimulus(32'h00000000, 32'd0,      32'd0,      0, 1, 0, 4'b1111, 32'd0,      32'd0,        5'd0, 1);
        applyStimulus(32'h00000000, 32'd0,      32'd0,      0, 1, 0, 4'b1111, 32'd0,      32'd0,        5'd0, 1);

        // Flush with a held entry and a same-cycle input
        applyStimulus(32'h002081B3, 32'd4,      32'd4,      1, 1, 0, 4'b0010, 32'd4,      32'd4,        5'd3, 0);
        applyStimulus(32'h402081B3, 32'd1,      32'd1,      1, 0, 1, 4'b0110, 32'd1,      32'd1,        5'd3, 0);
        applyStimulus(32'h00000000, 32'd0,      32'd0,      0, 1, 0, 4'b1111, 32'd0,      32'd0,        5'd0, 1);

        // Reset while an entry is held under backpressure
        applyStimulus(32'h007362B3, 32'h55,     32'hAA,     1, 0, 0, 4'b0001, 32'h55,     32'hAA,       5'd5, 0);
        applyStimulus(32'h00000000, 32'd0,      32'd0,      0, 0, 0, 4'b1111, 32'd0,      32'd0,        5'd0, 1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        scoreboard.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkResetState();
        applyStimulus(32'h00000000, 32'd0,      32'd0,      0, 1, 0, 4'b1111, 32'd0,      32'd0,        5'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
